ext_mem_loader: RTL and testbench

Parametrised external loader that fills instruction and/or data memory from a valid/ready word stream while the CPU is held in reset. It then releases the CPU after a programmable hold delay. It sits between the test harness and the riscv_cpu memories, replacing ad-hoc external write muxing with burst-counted, auto-incrementing, multi-target writes and an explicit CPU run-control FSM.

---
 rtl/ext_mem_loader.sv | 189 ++++++++++++++++++
 tb/tb_ext_mem_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_loader.sv
// ext_mem_loader: streams words into one of several memories while the CPU is
// held in reset, then releases the CPU after a programmable hold delay.
module ext_mem_loader #(
  parameter  int DATA_W      = 32,
  parameter  int ADDR_W      = 32,
  parameter  int NUM_TARGETS = 2,
  parameter  int MAX_BURST   = 256,
  parameter  int HOLD_CYCLES = 4,
  localparam int TSEL_W      = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1,
  localparam int CNT_W       = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_start,
  input  logic [TSEL_W-1:0]      ld_target,
  input  logic [ADDR_W-1:0]      ld_base_adr,
  input  logic [CNT_W-1:0]       ld_count,
  input  logic                   ld_abort,
  input  logic                   ld_go,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic [NUM_TARGETS-1:0] mem_we,
  output logic [ADDR_W-1:0]      mem_adr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [2:0]             mem_funct3,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [TSEL_W:0] NUM_TGT_EXT = (TSEL_W + 1)'(NUM_TARGETS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } stateT;

  stateT state;
  stateT stateNext;

  // Latched command
  logic [TSEL_W-1:0]      tgtLat;
  logic [ADDR_W-1:0]      baseLat;
  logic [CNT_W-1:0]       countLat;
  logic [CNT_W-1:0]       idx;
  logic [HOLD_W-1:0]      holdCnt;

  // Decoded control for the current cycle
  logic                   cmdValid;
  logic                   acceptCmd;
  logic                   rejectCmd;
  logic                   beat;
  logic                   lastBeat;
  logic                   goHold;

  // Registered write stage
  logic [NUM_TARGETS-1:0] memWe_p1;
  logic [ADDR_W-1:0]      memAdr_p1;
  logic [DATA_W-1:0]      memWdata_p1;
  logic                   done_p1;
  logic                   err_p1;

  // Next-state and per-cycle control decode; abort beats any beat in the same cycle
  always_comb begin
    stateNext = state;
    acceptCmd = 1'b0;
    rejectCmd = 1'b0;
    beat      = 1'b0;
    lastBeat  = 1'b0;
    goHold    = 1'b0;
    cmdValid  = (ld_count != '0) &&
                (ld_count <= CNT_W'(MAX_BURST)) &&
                ({1'b0, ld_target} < NUM_TGT_EXT) &&
                (ld_base_adr[1:0] == 2'b00);
    case (state)
      IDLE: begin
        if (ld_start) begin
          if (cmdValid) begin
            acceptCmd = 1'b1;
            stateNext = LOAD;
          end else begin
            rejectCmd = 1'b1;
          end
        end else if (ld_go) begin
          goHold    = 1'b1;
          stateNext = HOLD;
        end
      end
      LOAD: begin
        if (ld_abort) begin
          stateNext = IDLE;
        end else if (in_valid) begin
          beat = 1'b1;
          if (idx == countLat - CNT_W'(1)) begin
            lastBeat  = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      HOLD: begin
        if (holdCnt == HOLD_W'(1)) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        if (ld_start) begin
          if (cmdValid) begin
            acceptCmd = 1'b1;
            stateNext = LOAD;
          end else begin
            rejectCmd = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Command latch, beat index and hold-delay counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgtLat   <= '0;
      baseLat  <= '0;
      countLat <= '0;
      idx      <= '0;
      holdCnt  <= '0;
    end else begin
      if (acceptCmd) begin
        tgtLat   <= ld_target;
        baseLat  <= ld_base_adr;
        countLat <= ld_count;
        idx      <= '0;
      end else if (beat) begin
        idx <= idx + CNT_W'(1);
      end
      if (goHold) begin
        holdCnt <= HOLD_W'(HOLD_CYCLES);
      end else if (state == HOLD) begin
        holdCnt <= holdCnt - HOLD_W'(1);
      end
    end
  end

  // ---- stage p1: registered memory write and status pulses ----
  // Address and data hold between beats; only the enable drops back to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memWe_p1    <= '0;
      memAdr_p1   <= '0;
      memWdata_p1 <= '0;
      done_p1     <= 1'b0;
      err_p1      <= 1'b0;
    end else begin
      memWe_p1 <= '0;
      done_p1  <= lastBeat;
      err_p1   <= rejectCmd;
      if (beat) begin
        memWe_p1    <= NUM_TARGETS'(1) << tgtLat;
        memAdr_p1   <= baseLat + (ADDR_W'(idx) << 2);
        memWdata_p1 <= in_data;
      end
    end
  end

  assign mem_we     = memWe_p1;
  assign mem_adr    = memAdr_p1;
  assign mem_wdata  = memWdata_p1;
  assign mem_funct3 = 3'b010;
  assign done       = done_p1;
  assign err        = err_p1;
  assign in_ready   = (state == LOAD);
  assign busy       = (state == LOAD) || (state == HOLD);
  assign cpu_hold   = (state != RUN);

endmodule

// File: tb/tb_ext_mem_loader.sv
// Directed-plus-random bench for ext_mem_loader; expected writes come from a
// simple "remaining words" model of each load command.
module tb_ext_mem_loader;

  // Three targets so that an out-of-range target index is representable.
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int NUM_TARGETS = 3;
  localparam int MAX_BURST   = 256;
  localparam int HOLD_CYCLES = 4;
  localparam int TSEL_W      = 2;
  localparam int CNT_W       = 9;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   ld_start = 1'b0;
  logic [TSEL_W-1:0]      ld_target = '0;
  logic [ADDR_W-1:0]      ld_base_adr = '0;
  logic [CNT_W-1:0]       ld_count = '0;
  logic                   ld_abort = 1'b0;
  logic                   ld_go = 1'b0;
  logic                   in_valid = 1'b0;
  logic [DATA_W-1:0]      in_data = '0;
  logic                   in_ready;
  logic [NUM_TARGETS-1:0] mem_we;
  logic [ADDR_W-1:0]      mem_adr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [2:0]             mem_funct3;
  logic                   cpu_hold;
  logic                   busy;
  logic                   done;
  logic                   err;

  int total = 0;
  int bad   = 0;
  int preset[$];

  ext_mem_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_TARGETS(NUM_TARGETS),
    .MAX_BURST(MAX_BURST), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_target(ld_target),
    .ld_base_adr(ld_base_adr), .ld_count(ld_count), .ld_abort(ld_abort),
    .ld_go(ld_go), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one load and stream it. mode: 0 always valid, 1 alternating, 2 random.
  // abortAfter >= 0 raises ld_abort (with a valid beat) once that many words are written.
  task automatic runLoad(input int tgt, input logic [ADDR_W-1:0] base, input int cnt,
                         input int mode, input int abortAfter);
    int written;
    int cyc;
    logic v;
    logic ab;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] expAdr;
    logic [NUM_TARGETS-1:0] expWe;
    expWe = '0;
    expWe[tgt] = 1'b1;
    ld_start = 1'b1;
    ld_target = TSEL_W'(tgt);
    ld_base_adr = base;
    ld_count = CNT_W'(cnt);
    tick();
    ld_start = 1'b0;
    ld_go = 1'b0;
    chk("accept_ready", in_ready, 1);
    chk("accept_hold", cpu_hold, 1);
    chk("accept_busy", busy, 1);
    chk("accept_err", err, 0);
    written = 0;
    cyc = 0;
    while (written < cnt && cyc < 1000) begin
      chk("beat_ready", in_ready, 1);
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      ab = (abortAfter >= 0) && (written == abortAfter);
      if (ab) v = 1'b1;
      d = (preset.size() > 0) ? preset.pop_front() : $urandom;
      in_valid = v;
      in_data = d;
      ld_abort = ab;
      tick();
      in_valid = 1'b0;
      ld_abort = 1'b0;
      cyc++;
      if (ab) begin
        chk("abort_we", mem_we, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_busy", busy, 0);
        break;
      end
      if (v) begin
        expAdr = base + ADDR_W'(4 * written);
        chk("wr_we", mem_we, expWe);
        chk("wr_adr", mem_adr, expAdr);
        chk("wr_data", mem_wdata, d);
        chk("wr_funct3", mem_funct3, 3'b010);
        chk("wr_done", done, (written == cnt - 1));
        written++;
      end else begin
        chk("gap_we", mem_we, 0);
        chk("gap_done", done, 0);
      end
    end
    if (cyc >= 1000) chk("load_timeout", 1, 0);
    if (abortAfter < 0) begin
      chk("end_ready", in_ready, 0);
      chk("end_busy", busy, 0);
    end
    preset.delete();
  endtask

  task automatic rejectCmd(input logic [TSEL_W-1:0] tgt, input logic [ADDR_W-1:0] base,
                           input logic [CNT_W-1:0] cnt, input logic expHold);
    ld_start = 1'b1;
    ld_target = tgt;
    ld_base_adr = base;
    ld_count = cnt;
    tick();
    ld_start = 1'b0;
    chk("rej_err", err, 1);
    chk("rej_we", mem_we, 0);
    chk("rej_ready", in_ready, 0);
    chk("rej_busy", busy, 0);
    chk("rej_hold", cpu_hold, expHold);
    tick();
    chk("rej_err_clear", err, 0);
    chk("rej_ready2", in_ready, 0);
  endtask

  initial begin
    // Reset held low for three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", cpu_hold, 1);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_adr", mem_adr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_hold", cpu_hold, 1);
    chk("post_rst_ready", in_ready, 0);
    chk("post_rst_we", mem_we, 0);

    // Program words to instruction memory, stream always valid
    preset = '{32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233};
    runLoad(0, 32'h0, 4, 0, -1);

    // Data memory with gaps; ld_go together with ld_start must be ignored
    ld_go = 1'b1;
    runLoad(1, 32'h100, 3, 1, -1);
    chk("start_beats_go_hold", cpu_hold, 1);
    tick();
    chk("go_ignored_busy", busy, 0);
    chk("go_ignored_we", mem_we, 0);

    // Rejected commands
    rejectCmd(2'd0, 32'h0, 9'd0, 1'b1);
    rejectCmd(2'd0, 32'h102, 9'd4, 1'b1);
    rejectCmd(2'd3, 32'h0, 9'd4, 1'b1);
    rejectCmd(2'd1, 32'h0, 9'd257, 1'b1);

    // Random loads, back to back; one wraps the address space
    runLoad(2, 32'hFFFF_FFF8, 4, 2, -1);
    for (int k = 0; k < 4; k++) begin
      runLoad($urandom_range(0, 2), {$urandom_range(0, 32'h3FFF), 2'b00},
              $urandom_range(1, 20), 2, -1);
    end
    runLoad(0, 32'h40, MAX_BURST, 0, -1);

    // Release sequence: cpu_hold falls exactly HOLD_CYCLES edges after ld_go
    ld_go = 1'b1;
    tick();
    ld_go = 1'b0;
    chk("hold_cpu_hold0", cpu_hold, 1);
    chk("hold_busy0", busy, 1);
    for (int k = 1; k <= HOLD_CYCLES; k++) begin
      tick();
      chk("hold_cpu_hold", cpu_hold, (k < HOLD_CYCLES));
      chk("hold_busy", busy, (k < HOLD_CYCLES));
    end
    ld_go = 1'b1;
    tick();
    ld_go = 1'b0;
    chk("run_go_ignored", cpu_hold, 0);
    rejectCmd(2'd0, 32'h1, 9'd2, 1'b0);

    // Load from RUN puts the CPU back in reset on the accepting edge
    runLoad(1, 32'h200, 2, 0, -1);
    chk("run_load_hold", cpu_hold, 1);

    // Abort after three beats, abort coinciding with a valid beat
    runLoad(0, 32'h80, 8, 0, 3);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      tick();
      chk("post_abort_we", mem_we, 0);
      chk("post_abort_done", done, 0);
    end
    in_valid = 1'b0;

    // Reset pulled low mid-load stops writes immediately
    ld_start = 1'b1;
    ld_target = 2'd2;
    ld_base_adr = 32'h300;
    ld_count = 9'd8;
    tick();
    ld_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data = $urandom;
      tick();
      chk("pre_rst_we", mem_we, 3'b100);
    end
    in_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_we", mem_we, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_adr", mem_adr, 0);
    chk("midrst_hold", cpu_hold, 1);
    chk("midrst_busy", busy, 0);
    tick();
    chk("midrst_we2", mem_we, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("midrst_after_ready", in_ready, 0);
    chk("midrst_after_we", mem_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
